// File: rtl/nn_dtypes_pkg.sv
// Shared numeric types and constants for the NN datapath.
// Holds the fp32 field layout and the int32 saturation limits.
package nn_dtypes_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exponent;
    logic [22:0] mantissa;
  } fp32_t;

  localparam int FP32_BIAS = 127;

  localparam logic [31:0] INT32_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] INT32_MIN = 32'h8000_0000;

endpackage

// File: rtl/fp32_to_int32_if.sv
// Request/response bundle for the fp32 to int32 converter.
// The master drives the operand, the slave returns the result.
interface fp32_to_int32_if;
  import nn_dtypes_pkg::*;

  fp32_t              a;
  logic               start;
  logic signed [31:0] result;
  logic               done;
  logic               busy;
  logic               overflow;
  logic               invalid;

  modport master (
    output a, start,
    input  result, done, busy,
    input  overflow, invalid
  );

  modport slave (
    input  a, start,
    output result, done, busy,
    output overflow, invalid
  );

endinterface

// File: rtl/fp32_to_int32.sv
// Multi-cycle fp32 to signed int32 converter (4 cycles per op).
// FP32_TO_INT_RNE_EN: round-to-nearest-even, else truncate.
module fp32_to_int32
  import nn_dtypes_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  fp32_t              a,
  input  logic               start,
  output logic signed [31:0] result,
  output logic               done,
  output logic               busy,
  output logic               overflow,
  output logic               invalid
);

  typedef enum logic [1:0] {
    IDLE,
    UNPACK,
    CONVERT,
    DONE
  } state_t;

  state_t             state;
  fp32_t              op;
  logic               sgn;
  logic signed [9:0]  exp_u;
  logic [23:0]        sig;
  logic               nan;
  logic [31:0]        res_q;
  logic               ovf_q;
  logic               inv_q;

  logic [31:0]        res_c;
  logic               ovf_c;
  logic               inv_c;
  logic [31:0]        mag;
  logic [4:0]         lsh;
  logic [4:0]         rsh;
`ifdef FP32_TO_INT_RNE_EN
  logic [47:0]        ext;
  logic               guard;
  logic               sticky;
`endif

  // Scale the unpacked significand and apply saturation/sign
  always_comb begin
    res_c = '0;
    ovf_c = 1'b0;
    inv_c = 1'b0;
    mag   = '0;
    lsh   = 5'(exp_u - 10'sd23);
    rsh   = 5'(10'sd23 - exp_u);
`ifdef FP32_TO_INT_RNE_EN
    ext    = '0;
    guard  = 1'b0;
    sticky = 1'b0;
`endif
    if (nan) begin
      inv_c = 1'b1;
    end else if (exp_u >= 10'sd31) begin
      if (sgn && exp_u == 10'sd31
          && sig == 24'h80_0000) begin
        res_c = INT32_MIN;
      end else begin
        ovf_c = 1'b1;
        res_c = sgn ? INT32_MIN : INT32_MAX;
      end
    end else if (exp_u >= -10'sd1) begin
      if (exp_u >= 10'sd23) begin
        mag = {8'd0, sig} << lsh;
      end else begin
`ifdef FP32_TO_INT_RNE_EN
        ext    = {sig, 24'd0} >> rsh;
        mag    = {8'd0, ext[47:24]};
        guard  = ext[23];
        sticky = |ext[22:0];
        if (guard && (sticky || ext[24]))
          mag = mag + 32'd1;
`else
        mag = {8'd0, sig >> rsh};
`endif
      end
      res_c = sgn ? -mag : mag;
    end
  end

  // Sequencer: capture, unpack, convert, publish
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op       <= '0;
      sgn      <= 1'b0;
      exp_u    <= '0;
      sig      <= '0;
      nan      <= 1'b0;
      res_q    <= '0;
      ovf_q    <= 1'b0;
      inv_q    <= 1'b0;
      result   <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      overflow <= 1'b0;
      invalid  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            op    <= a;
            busy  <= 1'b1;
            state <= UNPACK;
          end
        end
        UNPACK: begin
          sgn   <= op.sign;
          exp_u <= $signed({2'b00, op.exponent})
                 - $signed(10'(FP32_BIAS));
          sig   <= {|op.exponent, op.mantissa};
          nan   <= (&op.exponent) && (|op.mantissa);
          state <= CONVERT;
        end
        CONVERT: begin
          res_q <= res_c;
          ovf_q <= ovf_c;
          inv_q <= inv_c;
          state <= DONE;
        end
        DONE: begin
          result   <= res_q;
          overflow <= ovf_q;
          invalid  <= inv_q;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_to_int32.sv
// Self-checking bench for fp32_to_int32: vectors, random,
// back-to-back streaming and mid-conversion reset.
module tb_fp32_to_int32;
  import nn_dtypes_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp32_to_int32_if bus();

  fp32_to_int32 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (bus.a),
    .start    (bus.start),
    .result   (bus.result),
    .done     (bus.done),
    .busy     (bus.busy),
    .overflow (bus.overflow),
    .invalid  (bus.invalid)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] r;
    logic        o;
    logic        v;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] opq[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  task automatic add(input logic [31:0] a,
                     input logic [31:0] r,
                     input logic o, input logic v);
    vec_t t;
    t.a = a; t.r = r; t.o = o; t.v = v;
    tbl.push_back(t);
  endtask

  // Reference: real-valued conversion from the fp32 fields
  function automatic void model(input logic [31:0] x,
                                output logic [31:0] r,
                                output logic o,
                                output logic v);
    int     ex;
    int     m;
    real    mg;
    real    fl;
    real    fr;
    longint iv;
    ex = int'(x[30:23]);
    m  = int'(x[22:0]);
    r = '0; o = 1'b0; v = 1'b0;
    if (ex == 255 && m != 0) begin
      v = 1'b1;
    end else if (ex == 255) begin
      o = 1'b1;
      r = x[31] ? INT32_MIN : INT32_MAX;
    end else if (ex != 0) begin
      mg = real'(m + 8388608) * (2.0 ** (ex - 150));
      fl = $floor(mg);
      fr = mg - fl;
`ifdef FP32_TO_INT_RNE_EN
      if (fr > 0.5 ||
          (fr == 0.5 && $floor(fl / 2.0) * 2.0 != fl))
        fl = fl + 1.0;
`endif
      if ((!x[31] && fl >= 2147483648.0) ||
          (x[31] && fl > 2147483648.0)) begin
        o = 1'b1;
        r = x[31] ? INT32_MIN : INT32_MAX;
      end else begin
        iv = longint'(fl);
        if (x[31]) iv = -iv;
        r = iv[31:0];
      end
    end
  endfunction

  task automatic run(input logic [31:0] x,
                     output logic [31:0] r,
                     output logic o, output logic v,
                     output int lat);
    @(negedge clk);
    bus.a = x;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a = ~x;
    lat = 0;
    while (!bus.done && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    r = bus.result;
    o = bus.overflow;
    v = bus.invalid;
  endtask

  logic [31:0] r, er;
  logic        o, v, eo, ev;
  int          lat;
  int          ndone;

  initial begin
    bus.a = '0;
    bus.start = 1'b0;

    add(32'h4040_0000, 32'd3, 1'b0, 1'b0);
`ifdef FP32_TO_INT_RNE_EN
    add(32'h4060_0000, 32'd4, 1'b0, 1'b0);
    add(32'h3FC0_0000, 32'd2, 1'b0, 1'b0);
    add(32'hBF40_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
`else
    add(32'h4060_0000, 32'd3, 1'b0, 1'b0);
    add(32'h3FC0_0000, 32'd1, 1'b0, 1'b0);
    add(32'hBF40_0000, 32'd0, 1'b0, 1'b0);
`endif
    add(32'hC020_0000, 32'hFFFF_FFFE, 1'b0, 1'b0);
    add(32'h3F00_0000, 32'd0, 1'b0, 1'b0);
    add(32'h3E80_0000, 32'd0, 1'b0, 1'b0);
    add(32'h5015_02F9, 32'h7FFF_FFFF, 1'b1, 1'b0);
    add(32'hFF80_0000, 32'h8000_0000, 1'b1, 1'b0);
    add(32'h7F80_0000, 32'h7FFF_FFFF, 1'b1, 1'b0);
    add(32'hCF00_0000, 32'h8000_0000, 1'b0, 1'b0);
    add(32'hCF00_0001, 32'h8000_0000, 1'b1, 1'b0);
    add(32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 1'b0);
    add(32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0, 1'b0);
    add(32'h4B00_0001, 32'h0080_0001, 1'b0, 1'b0);
    add(32'h7FC0_0000, 32'd0, 1'b0, 1'b1);
    add(32'h0000_0001, 32'd0, 1'b0, 1'b0);
    add(32'h8000_0000, 32'd0, 1'b0, 1'b0);

    #12;
    chk("rst_result", bus.result, 32'd0);
    chk("rst_flags",
        {29'd0, bus.done, bus.busy, bus.overflow}, 32'd0);
    chk("rst_invalid", {31'd0, bus.invalid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      run(tbl[i].a, r, o, v, lat);
      chk($sformatf("lat_%h", tbl[i].a), lat, 32'd3);
      chk($sformatf("res_%h", tbl[i].a), r, tbl[i].r);
      chk($sformatf("ovf_%h", tbl[i].a), {31'd0, o},
          {31'd0, tbl[i].o});
      chk($sformatf("inv_%h", tbl[i].a), {31'd0, v},
          {31'd0, tbl[i].v});
      @(posedge clk);
      #1;
      chk("hold_done", {31'd0, bus.done}, 32'd0);
      chk("hold_res", bus.result, tbl[i].r);
    end

    for (int i = 0; i < 300; i++) begin
      logic [31:0] x;
      x = $urandom;
      if (i % 2 == 0)
        x[30:23] = 8'($urandom_range(160, 100));
      model(x, er, eo, ev);
      run(x, r, o, v, lat);
      chk($sformatf("rnd_res_%h", x), r, er);
      chk($sformatf("rnd_flg_%h", x), {30'd0, o, v},
          {30'd0, eo, ev});
    end

    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      bus.a = $urandom;
      bus.a.exponent = 8'($urandom_range(150, 120));
      bus.start = 1'b1;
      if (k % 4 == 0) opq.push_back(bus.a);
      @(posedge clk);
      #1;
      chk($sformatf("b2b_done_%0d", k), {31'd0, bus.done},
          {31'd0, (k % 4 == 3)});
      if (bus.done) begin
        ndone++;
        if (opq.size() > 0) begin
          model(opq.pop_front(), er, eo, ev);
          chk($sformatf("b2b_res_%0d", k), bus.result, er);
          chk($sformatf("b2b_flg_%0d", k),
              {30'd0, bus.overflow, bus.invalid},
              {30'd0, eo, ev});
        end
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b_count", ndone, 32'd5);
    repeat (4) @(posedge clk);
    #1;

    run(32'h5015_02F9, r, o, v, lat);
    chk("pre_rst_ovf", {31'd0, o}, 32'd1);
    @(negedge clk);
    bus.a = 32'h4060_0000;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_result", bus.result, 32'd0);
    chk("mid_rst_flags",
        {28'd0, bus.done, bus.busy, bus.overflow, bus.invalid},
        32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) ndone++;
    end
    chk("post_rst_idle", ndone, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fp32_to_int32.md
FP32_TO_INT32 -- requirements
Module: fp32_to_int32

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-003 SHALL have port a  input  fp32_t (32)  operand; sampled only on the edge that accepts start.
REQ-004 SHALL have port start  input  1  request; accepted only in IDLE.
REQ-005 SHALL have port result  output  32 (signed)  converted integer; held until the next conversion completes.
REQ-006 SHALL have port done  output  1  one-cycle pulse marking result valid.
REQ-007 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-008 SHALL have port overflow  output  1  result saturated; valid with done, held until the next completion.
REQ-009 SHALL have port invalid  output  1  NaN input; valid with done, held until the next completion.

Function
REQ-010 SHALL implement FSM IDLE -> UNPACK -> CONVERT -> DONE -> IDLE, one state per cycle, no stalls.
REQ-011 SHALL, in IDLE with start=1 at edge N, capture a and enter UNPACK; done SHALL be high for exactly the cycle following edge N+3.
REQ-012 SHALL ignore start while busy=1; a captured operand SHALL NOT be altered by later changes on a.
REQ-013 SHALL accept start in the cycle done is high, giving back-to-back throughput of one conversion per 4 cycles.
REQ-014 SHALL, in UNPACK, register sign, unbiased exponent e = exponent - FP32_BIAS, and 24-bit significand {1, mantissa} (or {0, mantissa} when exponent == 0).
REQ-015 SHALL, in CONVERT, form the magnitude as significand << (e-23) when e >= 23, else significand >> (23-e), keeping guard and sticky bits from the discarded fraction.
REQ-016 SHALL negate the magnitude (two's complement) when sign=1.
REQ-017 SHALL return result 0 for exponent == 0 (zero or denormal), with overflow=0 and invalid=0.
REQ-018 SHALL return 0 for e < -1 in all configurations.
REQ-019 SHALL, when e >= 31 or on infinity, saturate to 0x7FFFFFFF (sign 0) or 0x80000000 (sign 1) and set overflow.
REQ-020 SHALL treat exactly -2^31 (0xCF000000) as exact: result 0x80000000 with overflow=0.
REQ-021 SHALL, on NaN (exponent 255, mantissa != 0), return 0, set invalid=1 and overflow=0.
REQ-022 SHALL, in DONE, update result/overflow/invalid together; these outputs SHALL NOT change at any other time.

Reset
REQ-023 SHALL, on rst_n low, force state IDLE, result 0, done 0, busy 0, overflow 0, invalid 0, regardless of clk.
REQ-024 SHALL abandon an in-flight conversion on reset; no done pulse SHALL follow reset release without a new start.

Configuration
REQ-025 SHALL use macro FP32_TO_INT_RNE_EN: defined -> round-to-nearest-even on guard/sticky (e = -1: >0.5 gives magnitude 1, exactly 0.5 gives 0); undefined -> truncate toward zero with no rounding logic.
REQ-026 SHALL keep ports and latency identical in both configurations.

Structure
REQ-027 SHALL import fp32_t and FP32_BIAS from nn_dtypes_pkg; INT32_MAX and INT32_MIN constants SHALL be added to nn_dtypes_pkg.
REQ-028 SHALL define the FSM state enum locally; no sub-module is warranted, and the block SHALL be a single module.

Verification
REQ-029 SHALL cover 0x40400000 (3.0) -> result 3, done at N+4, overflow=0, invalid=0.
REQ-030 SHALL cover 0x40600000 (3.5) -> 3 truncate / 4 RNE; 0xC0200000 (-2.5) -> -2 in both builds; 0x3F000000 (0.5) -> 0 in both builds.
REQ-031 SHALL cover 0x501502F9 (1e10) -> 0x7FFFFFFF with overflow=1; 0xFF800000 (-inf) -> 0x80000000 with overflow=1; 0xCF000000 -> 0x80000000 with overflow=0.
REQ-032 SHALL cover 0x7FC00000 (NaN) -> 0 with invalid=1; 0x00000001 (denormal) -> 0 with no flags.
REQ-033 SHALL cover start held high continuously with changing a -> exactly one done per 4 cycles, each result matching the operand captured at acceptance.
REQ-034 SHALL cover rst_n asserted in CONVERT -> all outputs 0 immediately and no done pulse after release.
